instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, the PC value loaded at reset.
REQ-002 The block SHALL have port orig_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port fetch_en  input  1  permits new ROM requests while high.
REQ-005 The block SHALL have port redirect  input  1  one-cycle branch/jump redirect from execute.
REQ-006 The block SHALL have port redirect_pc  input  8  new PC, sampled when redirect=1.
REQ-007 The block SHALL have port rom_req  output  1  instruction ROM read request.
REQ-008 The block SHALL have port rom_addr  output  8  ROM word address.
REQ-009 The block SHALL have port rom_ack  input  1  one-cycle pulse; rom_data valid in that cycle.
REQ-010 The block SHALL have port rom_data  input  32  instruction word from ROM.
REQ-011 The block SHALL have port instr  output  32  fetched instruction to decode.
REQ-012 The block SHALL have port instr_addr  output  8  address of instr.
REQ-013 The block SHALL have port instr_valid  output  1  instr/instr_addr hold a valid word.
REQ-014 The block SHALL have port instr_ready  input  1  decode accepts instr when instr_valid=1.
REQ-015 The block SHALL have port instr_count  output  16  count of instructions handed to decode.

Function
REQ-016 The block SHALL implement FSM states IDLE, FETCH, FULL; IDLE on reset.
REQ-017 IDLE: rom_req=0, instr_valid=0; fetch_en=1 -> FETCH next cycle.
REQ-018 FETCH: rom_req=1 and rom_addr=pc, both held stable until rom_ack or redirect.
REQ-019 FETCH with rom_ack=1: instr<=rom_data, instr_addr<=pc, pc<=pc+1 (8-bit wrap, 8'hFF -> 8'h00), -> FULL.
REQ-020 FULL: instr_valid=1, rom_req=0; instr, instr_addr held stable until handshake.
REQ-021 FULL with instr_valid&instr_ready: instr_count increments; next state FETCH if fetch_en=1, else IDLE.
REQ-022 Minimum latency: rom_ack in cycle N -> instr_valid=1 in cycle N+1; peak throughput one instruction per 2 cycles.
REQ-023 instr_count SHALL saturate at 16'hFFFF and never wrap.
REQ-024 redirect SHALL have highest priority in every state: pc<=redirect_pc, instr_valid=0 next cycle, next state FETCH if fetch_en=1 else IDLE.
REQ-025 A rom_ack coincident with redirect SHALL be discarded: no capture, no PC increment, no count.
REQ-026 Redirect in FULL coincident with instr_ready SHALL drop the held word uncounted.
REQ-027 ROM protocol: rom_ack is meaningful only while rom_req=1; rom_ack while rom_req=0 SHALL be ignored.
REQ-028 fetch_en falling in FETCH SHALL NOT cancel the outstanding request; it completes to FULL, then IDLE after handshake.
REQ-029 rom_req SHALL be 0 in the cycle following a redirect only if fetch_en=0; otherwise it is asserted with the new address in that next cycle.
REQ-030 No output SHALL depend combinationally on rom_data; instr is registered.

Reset
REQ-031 While rst_n=0, immediately and asynchronously: state=IDLE, pc=RESET_PC, rom_req=0, rom_addr=RESET_PC, instr=32'h0, instr_addr=8'h00, instr_valid=0, instr_count=16'h0000.
REQ-032 Reset asserted mid-request SHALL abandon the request; a rom_ack during reset is ignored.
REQ-033 After rst_n rises, the first rom_req SHALL be no earlier than the second rising edge with fetch_en=1.

Verification
REQ-034 Reset, fetch_en=1, ROM acks 2 cycles after each req, instr_ready=1 -> addresses 00,01,02 fetched in order, instr_count=3.
REQ-035 instr_ready=0 for 5 cycles while FULL at 8'h04 -> instr/instr_addr stable, rom_req=0, count unchanged; release -> count+1, next rom_addr=8'h05.
REQ-036 redirect with redirect_pc=8'h40 on same cycle as rom_ack for 8'h07 -> word dropped, next rom_addr=8'h40, count unchanged.
REQ-037 pc=8'hFF fetched and accepted -> next rom_addr=8'h00.
REQ-038 rst_n pulsed low while rom_req=1 at 8'h12 -> all outputs at reset values asynchronously, next fetch from RESET_PC.
REQ-039 Preload instr_count=16'hFFFE via 3 accepted fetches after forcing -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-word-deep fetch stage between an instruction ROM and decode.
// A redirect from execute overrides everything, and any ROM ack that coincides with it is dropped.
module instr_fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        orig_clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        redirect,
   input  logic [7:0]  redirect_pc,
   output logic        rom_req,
   output logic [7:0]  rom_addr,
   input  logic        rom_ack,
   input  logic [31:0] rom_data,
   output logic [31:0] instr,
   output logic [7:0]  instr_addr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [7:0]  r_pc;
   logic [31:0] r_instr;
   logic [7:0]  r_instrAddr;
   logic [15:0] r_instrCount;
   logic        w_capture;
   logic        w_handshake;

   assign w_capture   = (r_state == FETCH) && rom_ack && !redirect;
   assign w_handshake = (r_state == FULL) && instr_ready && !redirect;

   always_ff @(posedge orig_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Once a request is outstanding it runs to completion even if fetch_en drops.
   always_comb begin
      w_stateNext = r_state;
      if (redirect) begin
         w_stateNext = fetch_en ? FETCH : IDLE;
      end else begin
         case (r_state)
            IDLE:    if (fetch_en) w_stateNext = FETCH;
            FETCH:   if (rom_ack) w_stateNext = FULL;
            FULL:    if (instr_ready) w_stateNext = fetch_en ? FETCH : IDLE;
            default: w_stateNext = IDLE;
         endcase
      end
   end

   always_comb begin
      rom_req     = 1'b0;
      instr_valid = 1'b0;
      case (r_state)
         FETCH:   rom_req = 1'b1;
         FULL:    instr_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge orig_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RESET_PC;
         r_instr     <= 32'h0;
         r_instrAddr <= 8'h00;
      end else if (redirect) begin
         r_pc <= redirect_pc;
      end else if (w_capture) begin
         r_instr     <= rom_data;
         r_instrAddr <= r_pc;
         r_pc        <= r_pc + 8'd1;
      end
   end

   always_ff @(posedge orig_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instrCount <= 16'h0000;
      end else if (w_handshake && (r_instrCount != 16'hFFFF)) begin
         r_instrCount <= r_instrCount + 16'd1;
      end
   end

   assign rom_addr    = r_pc;
   assign instr       = r_instr;
   assign instr_addr  = r_instrAddr;
   assign instr_count = r_instrCount;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: the ROM and decode sides are driven by hand,
// and every expected value is computed from the stimulus.
module tb_instr_fetch_unit;

   logic        orig_clk;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        rom_req;
   logic [7:0]  rom_addr;
   logic        rom_ack;
   logic [31:0] rom_data;
   logic [31:0] instr;
   logic [7:0]  instr_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr_count;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(.RESET_PC(8'h00)) dut (
      .orig_clk    (orig_clk),
      .rst_n       (rst_n),
      .fetch_en    (fetch_en),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .rom_req     (rom_req),
      .rom_addr    (rom_addr),
      .rom_ack     (rom_ack),
      .rom_data    (rom_data),
      .instr       (instr),
      .instr_addr  (instr_addr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_count (instr_count)
   );

   initial begin
      orig_clk = 1'b0;
      forever #5 orig_clk = ~orig_clk;
   end

   function automatic logic [31:0] romWord(input logic [7:0] addr);
      return {8'hC0, addr, 8'hDE, ~addr};
   endfunction

   task automatic tick();
      @(posedge orig_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitReq();
      int n = 0;
      while (!rom_req && n < 20) begin
         tick();
         n++;
      end
      checkOutput("reqTimeout", {31'b0, rom_req}, 32'h1);
   endtask

   // Serve one ROM request: hold off the ack, then check the captured word one cycle later.
   task automatic applyStimulus(input logic [7:0] expAddr, input int ackDelay);
      waitReq();
      checkOutput("romAddr", {24'b0, rom_addr}, {24'b0, expAddr});
      for (int i = 0; i < ackDelay; i++) begin
         tick();
         checkOutput("reqHeld", {31'b0, rom_req}, 32'h1);
         checkOutput("addrHeld", {24'b0, rom_addr}, {24'b0, expAddr});
      end
      rom_ack  = 1'b1;
      rom_data = romWord(expAddr);
      tick();
      rom_ack  = 1'b0;
      rom_data = $urandom;
      checkOutput("validAfterAck", {31'b0, instr_valid}, 32'h1);
      checkOutput("instr", instr, romWord(expAddr));
      checkOutput("instrAddr", {24'b0, instr_addr}, {24'b0, expAddr});
      checkOutput("reqDropInFull", {31'b0, rom_req}, 32'h0);
   endtask

   task automatic checkReset();
      checkOutput("rstReq", {31'b0, rom_req}, 32'h0);
      checkOutput("rstAddr", {24'b0, rom_addr}, 32'h0);
      checkOutput("rstInstr", instr, 32'h0);
      checkOutput("rstInstrAddr", {24'b0, instr_addr}, 32'h0);
      checkOutput("rstValid", {31'b0, instr_valid}, 32'h0);
      checkOutput("rstCount", {16'b0, instr_count}, 32'h0);
   endtask

   initial begin
      rst_n       = 1'b0;
      fetch_en    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 8'h00;
      rom_ack     = 1'b0;
      rom_data    = 32'h0;
      instr_ready = 1'b0;
      #2;
      checkReset();
      tick();
      tick();
      #2;
      rst_n       = 1'b1;
      fetch_en    = 1'b1;
      instr_ready = 1'b1;
      #1;
      checkOutput("noReqBeforeEdge", {31'b0, rom_req}, 32'h0);

      // In-order fetch of 00,01,02 with a two-cycle ROM
      for (int a = 0; a < 3; a++) begin
         applyStimulus(8'(a), 2);
         tick();
         checkOutput("countSeq", {16'b0, instr_count}, 32'(a + 1));
      end

      // Decode back-pressure while holding the word at 04
      applyStimulus(8'h03, 2);
      tick();
      checkOutput("count4", {16'b0, instr_count}, 32'd4);
      instr_ready = 1'b0;
      applyStimulus(8'h04, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("stallValid", {31'b0, instr_valid}, 32'h1);
         checkOutput("stallInstr", instr, romWord(8'h04));
         checkOutput("stallAddr", {24'b0, instr_addr}, 32'h04);
         checkOutput("stallReq", {31'b0, rom_req}, 32'h0);
         checkOutput("stallCount", {16'b0, instr_count}, 32'd4);
      end
      instr_ready = 1'b1;
      tick();
      checkOutput("releaseCount", {16'b0, instr_count}, 32'd5);
      checkOutput("releaseAddr", {24'b0, rom_addr}, 32'h05);
      checkOutput("releaseReq", {31'b0, rom_req}, 32'h1);

      // Redirect to 40 coincident with the ack for 07
      applyStimulus(8'h05, 0);
      tick();
      applyStimulus(8'h06, 0);
      tick();
      checkOutput("count7", {16'b0, instr_count}, 32'd7);
      waitReq();
      checkOutput("addr07", {24'b0, rom_addr}, 32'h07);
      rom_ack     = 1'b1;
      rom_data    = romWord(8'h07);
      redirect    = 1'b1;
      redirect_pc = 8'h40;
      tick();
      rom_ack  = 1'b0;
      redirect = 1'b0;
      checkOutput("redirValid", {31'b0, instr_valid}, 32'h0);
      checkOutput("redirReq", {31'b0, rom_req}, 32'h1);
      checkOutput("redirAddr", {24'b0, rom_addr}, 32'h40);
      checkOutput("redirKeepInstrAddr", {24'b0, instr_addr}, 32'h06);
      checkOutput("redirCount", {16'b0, instr_count}, 32'd7);
      applyStimulus(8'h40, 1);
      tick();
      checkOutput("count8", {16'b0, instr_count}, 32'd8);

      // PC wrap from FF to 00
      redirect    = 1'b1;
      redirect_pc = 8'hFF;
      tick();
      redirect = 1'b0;
      checkOutput("addrFF", {24'b0, rom_addr}, 32'hFF);
      applyStimulus(8'hFF, 0);
      tick();
      checkOutput("count9", {16'b0, instr_count}, 32'd9);
      checkOutput("wrapAddr", {24'b0, rom_addr}, 32'h00);

      // Redirect in FULL together with instr_ready drops the word uncounted
      applyStimulus(8'h00, 0);
      redirect    = 1'b1;
      redirect_pc = 8'h20;
      tick();
      redirect = 1'b0;
      checkOutput("dropValid", {31'b0, instr_valid}, 32'h0);
      checkOutput("dropCount", {16'b0, instr_count}, 32'd9);
      checkOutput("dropAddr", {24'b0, rom_addr}, 32'h20);

      // fetch_en falling mid-request, then a stray ack while idle
      fetch_en = 1'b0;
      tick();
      checkOutput("enLowReq", {31'b0, rom_req}, 32'h1);
      applyStimulus(8'h20, 0);
      tick();
      checkOutput("count10", {16'b0, instr_count}, 32'd10);
      checkOutput("idleReq", {31'b0, rom_req}, 32'h0);
      rom_ack  = 1'b1;
      rom_data = 32'hDEADBEEF;
      tick();
      rom_ack = 1'b0;
      checkOutput("strayValid", {31'b0, instr_valid}, 32'h0);
      checkOutput("strayCount", {16'b0, instr_count}, 32'd10);
      checkOutput("strayAddr", {24'b0, rom_addr}, 32'h21);
      checkOutput("strayInstrAddr", {24'b0, instr_addr}, 32'h20);

      // Asynchronous reset during a request at 12
      fetch_en    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 8'h12;
      tick();
      redirect = 1'b0;
      checkOutput("req12", {31'b0, rom_req}, 32'h1);
      checkOutput("addr12", {24'b0, rom_addr}, 32'h12);
      #2;
      rst_n    = 1'b0;
      rom_ack  = 1'b1;
      rom_data = romWord(8'h12);
      #1;
      checkReset();
      tick();
      checkReset();
      rom_ack = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      checkOutput("postRstReq", {31'b0, rom_req}, 32'h0);
      tick();
      checkOutput("postRstFetch", {31'b0, rom_req}, 32'h1);
      applyStimulus(8'h00, 0);
      fetch_en = 1'b0;
      tick();
      checkOutput("postRstCount", {16'b0, instr_count}, 32'd1);

      // Counter saturation from a forced FFFE
      @(negedge orig_clk);
      force dut.r_instrCount = 16'hFFFE;
      tick();
      release dut.r_instrCount;
      tick();
      checkOutput("preloadCount", {16'b0, instr_count}, 32'hFFFE);
      fetch_en = 1'b1;
      for (int a = 1; a <= 3; a++) begin
         applyStimulus(8'(a), 0);
         tick();
         checkOutput("satCount", {16'b0, instr_count}, 32'hFFFF);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
